// File: rtl/sram_burst_if.sv
// Host-side command, write-data and read-data channels of the burst SRAM controller.
// master = network-side requester, slave = controller.
interface sram_burst_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [1:0]        cmd_be;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be, wr_data, wr_valid,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be, wr_data, wr_valid,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, busy
    );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Asynchronous-mode PSRAM controller: burst reads/writes with byte enables,
// programmable wait states and address auto-increment.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WDATA   | write word requested, strobes inactive until wr_valid
// SETUP   | CE and lanes low; OE low for reads, data driven for writes
// ACCESS  | wait-state window; WE low for writes, capture on last read cycle
// RECOVER | strobes inactive, write data held; advance address/count
// DONE    | one-cycle completion pulse
module sram_burst_ctrl #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 16,
    parameter int READ_WAIT  = 4,
    parameter int WRITE_WAIT = 4,
    parameter int LEN_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_burst_if.slave       bus,
    output logic [ADDR_W-1:0] mem_adr,
    inout  wire  [DATA_W-1:0] mem_db,
    output logic              ram_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              ram_lb_n,
    output logic              ram_ub_n,
    output logic              ram_adv_n,
    output logic              ram_clk,
    output logic              flash_ce_n
);

    localparam int WAIT_MAX = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] RD_LOAD = WAIT_W'(READ_WAIT - 1);
    localparam logic [WAIT_W-1:0] WR_LOAD = WAIT_W'(WRITE_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        RECOVER,
        DONE
    } state_t;

    state_t state, state_d;

    logic              write_q, write_d;
    logic [1:0]        be_q, be_d;
    logic [LEN_W-1:0]  count_q;
    logic [WAIT_W-1:0] wait_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              drive_q, drive_d;
    logic              ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;
    logic              ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d;
    logic              accept, wr_take, step, capture, bus_cycle_d;

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        wr_take = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = bus.cmd_write ? WDATA : SETUP;
                end
            end
            WDATA: begin
                if (bus.wr_valid) begin
                    wr_take = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS:  if (wait_q == '0) state_d = RECOVER;
            RECOVER: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    step    = 1'b1;
                    state_d = write_q ? WDATA : SETUP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin strobes are registered from the next state so the pads never see decode glitches.
    always_comb begin
        write_d     = accept ? bus.cmd_write : write_q;
        be_d        = accept ? bus.cmd_be : be_q;
        bus_cycle_d = (state_d == SETUP) || (state_d == ACCESS);
        ce_n_d      = !bus_cycle_d;
        oe_n_d      = !(bus_cycle_d && !write_d);
        we_n_d      = !((state_d == ACCESS) && write_d);
        lb_n_d      = !(bus_cycle_d && be_d[0]);
        ub_n_d      = !(bus_cycle_d && be_d[1]);
        drive_d     = write_d && ((state_d == SETUP) || (state_d == ACCESS) ||
                                  (state_d == RECOVER));
    end

    assign capture = (state == ACCESS) && (wait_q == '0) && !write_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            be_q       <= 2'b00;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            drive_q    <= 1'b0;
            count_q    <= '0;
            adr_q      <= '0;
            wdata_q    <= '0;
            wait_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            write_q    <= write_d;
            be_q       <= be_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            lb_n_q     <= lb_n_d;
            ub_n_q     <= ub_n_d;
            drive_q    <= drive_d;
            rd_valid_q <= capture;
            if (accept) begin
                count_q <= bus.cmd_len;
                adr_q   <= bus.cmd_addr;
            end else if (step) begin
                count_q <= count_q - LEN_W'(1);
                adr_q   <= adr_q + ADDR_W'(1);
            end
            if (wr_take) begin
                wdata_q <= bus.wr_data;
            end
            if (state == SETUP) begin
                wait_q <= write_q ? WR_LOAD : RD_LOAD;
            end else if ((state == ACCESS) && (wait_q != '0)) begin
                wait_q <= wait_q - WAIT_W'(1);
            end
            if (capture) begin
                rd_data_q <= mem_db;
            end
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.wr_ready  = (state == WDATA);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;

    assign mem_adr    = adr_q;
    assign mem_db     = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign ram_ce_n   = ce_n_q;
    assign mem_oe_n   = oe_n_q;
    assign mem_we_n   = we_n_q;
    assign ram_lb_n   = lb_n_q;
    assign ram_ub_n   = ub_n_q;
    assign ram_adv_n  = 1'b0;
    assign ram_clk    = 1'b0;
    assign flash_ce_n = 1'b1;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl: PSRAM behavioural model plus a scoreboard
// monitor checking read data, write pulses and bus-protocol invariants.
`timescale 1ns/1ps
module tb_sram_burst_ctrl;
    localparam int ADDR_W     = 23;
    localparam int DATA_W     = 16;
    localparam int READ_WAIT  = 4;
    localparam int WRITE_WAIT = 4;
    localparam int LEN_W      = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    wire  [DATA_W-1:0] mem_db;
    logic [ADDR_W-1:0] mem_adr;
    logic ram_ce_n, mem_oe_n, mem_we_n, ram_lb_n, ram_ub_n;
    logic ram_adv_n, ram_clk, flash_ce_n;

    sram_burst_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_WAIT(READ_WAIT),
        .WRITE_WAIT(WRITE_WAIT), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mem_adr(mem_adr), .mem_db(mem_db),
        .ram_ce_n(ram_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n),
        .ram_adv_n(ram_adv_n), .ram_clk(ram_clk), .flash_ce_n(flash_ce_n)
    );

    // PSRAM model: drives the bus while CE/OE are low, writes enabled lanes while WE is low.
    logic [15:0] sram [logic [22:0]];
    logic [15:0] model_rd = 16'h0000;

    function automatic logic [15:0] lookup(input logic [22:0] a);
        return sram.exists(a) ? sram[a] : 16'h0000;
    endfunction

    assign mem_db = (!ram_ce_n && !mem_oe_n) ? model_rd : 16'hzzzz;

    always @(negedge clk) begin
        logic [15:0] old;
        model_rd <= lookup(mem_adr);
        if (!ram_ce_n && !mem_we_n) begin
            old = lookup(mem_adr);
            sram[mem_adr] = {ram_ub_n ? old[15:8] : mem_db[15:8],
                             ram_lb_n ? old[7:0]  : mem_db[7:0]};
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [22:0] addr;
        logic [15:0] data;
    } wr_t;

    logic [15:0] rd_exp[$];
    wr_t         wr_exp[$];

    int   oe_len = 0, we_len = 0, we_pulses = 0, rd_cnt = 0, done_cnt = 0;
    logic ub_hold = 1'b0;
    wr_t  mon_e;
    logic [15:0] mon_d;

    always @(negedge clk) begin
        if (!rst_n) begin
            oe_len = 0;
            we_len = 0;
        end else begin
            if (!mem_oe_n) begin
                check("we_during_oe", 32'(mem_we_n), 32'(1'b1));
                check("read_bus_clean", 32'(mem_db), 32'(model_rd));
                oe_len++;
            end else if (oe_len != 0) begin
                check("oe_pulse_len", 32'(oe_len), 32'(1 + READ_WAIT));
                oe_len = 0;
            end
            if (!mem_we_n) begin
                we_len++;
            end else if (we_len != 0) begin
                we_pulses++;
                check("we_pulse_len", 32'(we_len), 32'(WRITE_WAIT));
                we_len = 0;
                checks++;
                if (wr_exp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h, no write expected", mem_adr);
                end else begin
                    mon_e = wr_exp.pop_front();
                    check("write_addr", 32'(mem_adr), 32'(mon_e.addr));
                    check("write_cell", 32'(lookup(mon_e.addr)), 32'(mon_e.data));
                end
            end
            if (bus.rd_valid) begin
                rd_cnt++;
                checks++;
                if (rd_exp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rd_valid: got 0x%0h, no read expected", bus.rd_data);
                end else begin
                    mon_d = rd_exp.pop_front();
                    check("rd_data", 32'(bus.rd_data), 32'(mon_d));
                end
            end
            if (bus.done) done_cnt++;
            if (bus.wr_ready)
                check("wdata_strobes_idle",
                      32'({ram_ce_n, mem_we_n, mem_oe_n, ram_lb_n, ram_ub_n}), 32'(5'b11111));
            if (bus.busy) check("cmd_ready_while_busy", 32'(bus.cmd_ready), 32'(1'b0));
            if (ub_hold) check("ub_held_high", 32'(ram_ub_n), 32'(1'b1));
        end
    end

    task automatic send_cmd(input logic w, input logic [22:0] a, input logic [3:0] l,
                            input logic [1:0] be);
        int n = 0;
        @(negedge clk);
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_be    = be;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 32'(bus.cmd_ready), 32'(1'b1));
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [15:0] d, input int gap);
        int n = 0;
        if (gap > 0) bus.wr_valid = 1'b0;
        else bus.wr_valid = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        while (!bus.wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready_seen", 32'(bus.wr_ready), 32'(1'b1));
        for (int i = 0; i < gap; i++) begin
            check("wr_ready_held", 32'(bus.wr_ready), 32'(1'b1));
            @(negedge clk);
        end
        bus.wr_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.done), 32'(1'b1));
        @(negedge clk);
        check("busy_after_done", 32'(bus.busy), 32'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, p0, d0, n;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_be    = 2'b00;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        sram[23'h000010] = 16'hBEEF;
        sram[23'h005555] = 16'h5555;

        repeat (3) @(negedge clk);
        check("rst_strobes", 32'({ram_ce_n, mem_oe_n, mem_we_n, ram_lb_n, ram_ub_n}),
              32'(5'b11111));
        check("rst_busy", 32'(bus.busy), 32'(1'b0));
        check("rst_done", 32'(bus.done), 32'(1'b0));
        check("rst_rd_valid", 32'(bus.rd_valid), 32'(1'b0));
        check("rst_rd_data", 32'(bus.rd_data), 32'(16'h0000));
        check("rst_mem_adr", 32'(mem_adr), 32'(23'h0));
        check("const_pins", 32'({ram_adv_n, ram_clk, flash_ce_n}), 32'(3'b001));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'(1'b1));

        // single-word read
        rd_exp.push_back(16'hBEEF);
        r0 = rd_cnt;
        send_cmd(1'b0, 23'h000010, 4'd0, 2'b11);
        wait_done("read_done");
        check("read_rd_valid_count", 32'(rd_cnt - r0), 32'd1);

        // wrapping write burst, wr_valid held high
        wr_exp.push_back('{23'h7FFFFE, 16'h1111});
        wr_exp.push_back('{23'h7FFFFF, 16'h2222});
        wr_exp.push_back('{23'h000000, 16'h3333});
        wr_exp.push_back('{23'h000001, 16'h4444});
        p0 = we_pulses;
        send_cmd(1'b1, 23'h7FFFFE, 4'd3, 2'b11);
        feed_word(16'h1111, 0);
        feed_word(16'h2222, 0);
        feed_word(16'h3333, 0);
        feed_word(16'h4444, 0);
        wait_done("wburst_done");
        bus.wr_valid = 1'b0;
        check("wburst_we_pulses", 32'(we_pulses - p0), 32'd4);
        check("wburst_cell0", 32'(lookup(23'h000000)), 32'(16'h3333));
        check("wburst_cell1", 32'(lookup(23'h000001)), 32'(16'h4444));

        // read the wrapped burst back while hammering cmd_valid during busy
        rd_exp.push_back(16'h1111);
        rd_exp.push_back(16'h2222);
        rd_exp.push_back(16'h3333);
        rd_exp.push_back(16'h4444);
        d0 = done_cnt;
        r0 = rd_cnt;
        send_cmd(1'b0, 23'h7FFFFE, 4'd3, 2'b11);
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 23'h000123;
        bus.cmd_valid = 1'b1;
        repeat (6) @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_done("rburst_done");
        check("rburst_rd_count", 32'(rd_cnt - r0), 32'd4);
        check("rburst_single_done", 32'(done_cnt - d0), 32'd1);

        // byte-lane write: lower lane only
        ub_hold = 1'b1;
        wr_exp.push_back('{23'h005555, 16'h55CD});
        send_cmd(1'b1, 23'h005555, 4'd0, 2'b01);
        feed_word(16'hABCD, 0);
        wait_done("be_done");
        bus.wr_valid = 1'b0;
        ub_hold = 1'b0;

        // two-word write with a 7-cycle wr_valid gap before the second word
        wr_exp.push_back('{23'h000100, 16'hA1A1});
        wr_exp.push_back('{23'h000101, 16'hB2B2});
        send_cmd(1'b1, 23'h000100, 4'd1, 2'b11);
        feed_word(16'hA1A1, 0);
        feed_word(16'hB2B2, 7);
        wait_done("gap_done");
        bus.wr_valid = 1'b0;
        check("gap_cell0", 32'(lookup(23'h000100)), 32'(16'hA1A1));
        check("gap_cell1", 32'(lookup(23'h000101)), 32'(16'hB2B2));

        // reset in the middle of a write ACCESS
        send_cmd(1'b1, 23'h000200, 4'd0, 2'b11);
        bus.wr_data  = 16'h7777;
        bus.wr_valid = 1'b1;
        n = 0;
        while (mem_we_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_access", 32'(mem_we_n), 32'(1'b0));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        d0 = done_cnt;
        #1;
        check("abort_strobes", 32'({ram_ce_n, mem_oe_n, mem_we_n, ram_lb_n, ram_ub_n}),
              32'(5'b11111));
        check("abort_busy", 32'(bus.busy), 32'(1'b0));
        check("abort_done", 32'(bus.done), 32'(1'b0));
        bus.wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_cmd_ready", 32'(bus.cmd_ready), 32'(1'b1));
        rd_exp.push_back(16'hBEEF);
        send_cmd(1'b0, 23'h000010, 4'd0, 2'b11);
        wait_done("post_reset_read_done");

        repeat (3) @(negedge clk);
        check("rd_queue_drained", 32'(rd_exp.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_exp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
